// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 decryptor phase scheduler.
package rc4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_KSA   = 3'd2,
    ST_PRGA  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } phase_t;

  localparam logic [1:0] FP_NONE = 2'd0;
  localparam logic [1:0] FP_INIT = 2'd1;
  localparam logic [1:0] FP_KSA  = 2'd2;
  localparam logic [1:0] FP_PRGA = 2'd3;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned TIMEOUT_DEF = 4096;

  function automatic logic [1:0] fault_code(input phase_t p);
    logic [1:0] code;
    code = FP_NONE;
    case (p)
      ST_INIT: code = FP_INIT;
      ST_KSA:  code = FP_KSA;
      ST_PRGA: code = FP_PRGA;
      default: code = FP_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rc4_sched_watchdog.sv
// Per-phase cycle counter; expired flags the last permitted cycle of a phase.
module phase_watchdog import rc4_pkg::*; #(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/rc4_sched.sv
// RC4 phase scheduler: sequences INIT/KSA/PRGA engines, guards each phase
// with a watchdog and gives the single-port S memory to the active engine.
module rc4_sched import rc4_pkg::*; #(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              run_prga,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        phase,
  output logic [1:0]        fault_phase,
  output logic              init_start,
  output logic              ksa_start,
  output logic              prga_start,
  input  logic              init_done,
  input  logic              ksa_done,
  input  logic              prga_done,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic [DATA_W-1:0] ksa_data,
  input  logic [DATA_W-1:0] prga_data,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_data,
  output logic              s_wren
);

  phase_t     state, state_next;
  logic       rp_q, rp_next;
  logic [1:0] fault_next;
  logic       running, expired;

  assign running = (state == ST_INIT) || (state == ST_KSA) || (state == ST_PRGA);

  phase_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_next != state),
    .enable (running),
    .expired(expired)
  );

  // The engine's *_start pulse doubles as the done-blanking window.
  always_comb begin
    state_next = state;
    rp_next    = rp_q;
    fault_next = fault_phase;
    case (state)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start) begin
          state_next = ST_INIT;
          rp_next    = run_prga;
          fault_next = FP_NONE;
        end
      end
      ST_INIT: begin
        if (!init_start && init_done) state_next = ST_KSA;
        else if (expired)             state_next = ST_FAULT;
      end
      ST_KSA: begin
        if (!ksa_start && ksa_done)   state_next = rp_q ? ST_PRGA : ST_DONE;
        else if (expired)             state_next = ST_FAULT;
      end
      ST_PRGA: begin
        if (!prga_start && prga_done) state_next = ST_DONE;
        else if (expired)             state_next = ST_FAULT;
      end
      default: state_next = ST_IDLE;
    endcase
    if (running && state_next == ST_FAULT) fault_next = fault_code(state);
    if (abort) begin
      state_next = ST_IDLE;
      rp_next    = rp_q;
      fault_next = fault_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rp_q        <= 1'b0;
      fault_phase <= FP_NONE;
      init_start  <= 1'b0;
      ksa_start   <= 1'b0;
      prga_start  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_next;
      rp_q        <= rp_next;
      fault_phase <= fault_next;
      init_start  <= (state_next == ST_INIT) && (state != ST_INIT);
      ksa_start   <= (state_next == ST_KSA)  && (state != ST_KSA);
      prga_start  <= (state_next == ST_PRGA) && (state != ST_PRGA);
      busy        <= (state_next == ST_INIT) || (state_next == ST_KSA) ||
                     (state_next == ST_PRGA);
      done        <= (state_next == ST_DONE);
      error       <= (state_next == ST_FAULT);
    end
  end

  assign phase = state;

  always_comb begin
    s_addr = '0;
    s_data = '0;
    s_wren = 1'b0;
    case (state)
      ST_INIT: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wren = init_wren;
      end
      ST_KSA: begin
        s_addr = ksa_addr;
        s_data = ksa_data;
        s_wren = ksa_wren;
      end
      ST_PRGA: begin
        s_addr = prga_addr;
        s_data = prga_data;
        s_wren = prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_sched.sv
// Self-checking bench for rc4_sched: phase timeline computed from engine
// latencies, randomized engine buses, abort/reset/timeout scenarios.
module tb_rc4_sched;

  localparam int TO = 1024;
  localparam int P_IDLE = 0, P_INIT = 1, P_KSA = 2, P_PRGA = 3, P_DONE = 4, P_FAULT = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, abort = 1'b0, run_prga = 1'b0;
  logic       busy, done, error, init_start, ksa_start, prga_start;
  logic [2:0] phase;
  logic [1:0] fault_phase;
  logic       init_done = 1'b0, ksa_done = 1'b0, prga_done = 1'b0;
  logic [7:0] init_addr = '0, ksa_addr = '0, prga_addr = '0;
  logic [7:0] init_data = '0, ksa_data = '0, prga_data = '0;
  logic       init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;
  logic [7:0] s_addr, s_data;
  logic       s_wren;

  int total = 0;
  int bad = 0;
  int m_ph = P_IDLE;
  int m_fp = 0;
  bit lv[3];

  always #5 clk = ~clk;

  rc4_sched #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .run_prga(run_prga),
    .busy(busy), .done(done), .error(error), .phase(phase), .fault_phase(fault_phase),
    .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
    .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Phase/offset/fault code at cycle t after INIT entry, from engine latencies.
  function automatic void where(input int t, input int d0, input int d1, input int d2,
                                input bit rp, output int ph, output int off, output int fp);
    int base, d;
    base = 0; ph = P_DONE; off = 0; fp = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2 && !rp) return;
      d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
      if (d <= TO - 1) begin
        if (t < base + d + 1) begin ph = k + 1; off = t - base; return; end
        base += d + 1;
      end else begin
        if (t < base + TO) begin ph = k + 1; off = t - base; return; end
        ph = P_FAULT; fp = k + 1; return;
      end
    end
  endfunction

  task automatic rand_buses();
    init_addr = 8'($urandom); ksa_addr = 8'($urandom); prga_addr = 8'($urandom);
    init_data = 8'($urandom); ksa_data = 8'($urandom); prga_data = 8'($urandom);
    init_wren = 1'($urandom); ksa_wren = 1'($urandom); prga_wren = 1'($urandom);
  endtask

  task automatic drive_dones();
    init_done = lv[0]; ksa_done = lv[1]; prga_done = lv[2];
  endtask

  task automatic check_all(input int ph, input int off, input int fp);
    logic [7:0] ea, ed;
    logic       ew;
    ea = '0; ed = '0; ew = 1'b0;
    if (ph == P_INIT) begin ea = init_addr; ed = init_data; ew = init_wren; end
    if (ph == P_KSA)  begin ea = ksa_addr;  ed = ksa_data;  ew = ksa_wren;  end
    if (ph == P_PRGA) begin ea = prga_addr; ed = prga_data; ew = prga_wren; end
    chk("phase", phase, ph);
    chk("busy", busy, (ph >= P_INIT && ph <= P_PRGA));
    chk("done", done, ph == P_DONE);
    chk("error", error, ph == P_FAULT);
    chk("fault_phase", fault_phase, fp);
    chk("init_start", init_start, ph == P_INIT && off == 0);
    chk("ksa_start", ksa_start, ph == P_KSA && off == 0);
    chk("prga_start", prga_start, ph == P_PRGA && off == 0);
    chk("s_addr", s_addr, ea);
    chk("s_data", s_data, ed);
    chk("s_wren", s_wren, ew);
  endtask

  task automatic run(input int d0, input int d1, input int d2, input bit rp,
                     input int abort_at, input int reset_at);
    int ph, off, fp, halt_t, hold_fp, tail, eng, d;
    bit by_reset;
    halt_t = -1; hold_fp = 0; tail = 0; by_reset = 0; ph = m_ph; fp = m_fp;
    @(posedge clk); #1;
    start = 1'b1; run_prga = rp; abort = 1'b0; reset = 1'b0;
    rand_buses(); drive_dones();
    #1 check_all(m_ph, 1, m_fp);
    for (int t = 0; t < 20000 && tail < 3; t++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; reset = 1'b0; run_prga = 1'($urandom);
      rand_buses();
      if (halt_t >= 0) begin
        ph = P_IDLE; off = 0; fp = by_reset ? 0 : hold_fp;
      end else begin
        where(t, d0, d1, d2, rp, ph, off, fp);
      end
      if (ph >= P_INIT && ph <= P_PRGA) begin
        eng = ph - 1;
        d = (eng == 0) ? d0 : (eng == 1) ? d1 : d2;
        if (off == 0) begin
          drive_dones();
          lv[eng] = 1'b0;
        end else begin
          if (off >= d) lv[eng] = 1'b1;
          drive_dones();
        end
        if ($urandom_range(0, 7) == 0) start = 1'b1;
      end else begin
        drive_dones();
      end
      if (t == abort_at) begin abort = 1'b1; halt_t = t; hold_fp = fp; by_reset = 0; end
      if (t == reset_at) begin reset = 1'b1; halt_t = t; by_reset = 1; end
      #1 check_all(ph, off, fp);
      if (ph == P_DONE || ph == P_FAULT || ph == P_IDLE) tail++;
    end
    m_ph = ph; m_fp = fp;
  endtask

  initial begin
    lv[0] = 0; lv[1] = 0; lv[2] = 0;
    rand_buses();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_all(P_IDLE, 0, 0);

    // Full run with PRGA, textbook engine latencies
    run(256, 768, 100, 1'b1, -1, -1);
    // Stop after key schedule; init_done is stale-high at the next start
    run(20, 30, 5, 1'b0, -1, -1);
    run(1, 1, 1, 1'b1, -1, -1);
    // KSA watchdog expiry
    run(5, TO + 10, 5, 1'b1, -1, -1);
    // Done arriving in the expiry cycle wins
    run(TO - 1, 3, 2, 1'b1, -1, -1);
    // Abort mid-PRGA
    run(3, 4, 50, 1'b1, 19, -1);
    // INIT timeout, then start+abort together: abort wins, fault code kept
    run(TO + 5, 3, 3, 1'b1, -1, -1);
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; rand_buses(); drive_dones();
    #1 check_all(m_ph, 1, m_fp);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; rand_buses(); drive_dones();
    #1 check_all(P_IDLE, 0, m_fp);
    m_ph = P_IDLE;
    // Reset mid-KSA, then a clean run
    run(2, 100, 5, 1'b1, -1, 20);
    run(7, 9, 11, 1'b1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      run($urandom_range(1, 60), $urandom_range(1, 60), $urandom_range(1, 60),
          1'($urandom), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
